// File: rtl/relu_pool1.sv
//------------------------------------------------------------------------------
// relu_pool1
//
// Post-processing stage behind the first convolution layer. Each completed
// IN_H x IN_W channel of signed 24-bit sums is snapshotted, then one 2x2 window
// per cycle is reduced: signed max, ReLU, right shift by SHIFT and saturation
// to 8 bits. The result lands in a per-channel OUT_H x OUT_W feature map.
//
// Optional build macro:
//   RELU_POOL1_ROUND_EN  round-to-nearest before the shift (default: truncate)
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_buff   upstream channel result, signed 24-bit [IN_H][IN_W]
//   in_valid  one-cycle pulse, in_buff holds a complete channel
//   in_chan   channel index of in_buff, qualified by in_valid
//   out_fmap  pooled unsigned feature maps [CHAN][OUT_H][OUT_W], registered
//   ch_valid  one-cycle pulse, channel ch_idx fully written
//   ch_idx    channel just completed
//   all_done  one-cycle pulse with ch_valid when ch_idx == CHAN-1
//   busy      high while a channel is being processed
//   overrun   sticky: request while busy or with out-of-range channel
//------------------------------------------------------------------------------
module relu_pool1 #(
   parameter int IN_H  = 14,
   parameter int IN_W  = 13,
   parameter int OUT_H = 7,
   parameter int OUT_W = 6,
   parameter int CHAN  = 10,
   parameter int SHIFT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [23:0] in_buff  [0:IN_H-1][0:IN_W-1],
   input  logic               in_valid,
   input  logic [3:0]         in_chan,
   output logic [7:0]         out_fmap [0:CHAN-1][0:OUT_H-1][0:OUT_W-1],
   output logic               ch_valid,
   output logic [3:0]         ch_idx,
   output logic               all_done,
   output logic               busy,
   output logic               overrun
);

   localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT_H - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(OUT_W - 1);
   localparam logic [3:0]       CHAN_LAST = 4'(CHAN - 1);

   typedef enum logic [1:0] {S_IDLE, S_POOL, S_DONE} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic signed [23:0] r_snap [0:IN_H-1][0:IN_W-1];
   logic [7:0]         r_fmap [0:CHAN-1][0:OUT_H-1][0:OUT_W-1];
   logic [3:0]         r_chan;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic               r_ch_valid;
   logic [3:0]         r_ch_idx;
   logic               r_all_done;
   logic               r_busy;
   logic               r_overrun;

   logic               w_chan_ok;
   logic               w_accept;
   logic               w_last;
   logic               w_wr_en;
   logic               w_done;
   logic               w_all;
   logic               w_err;

   logic [ROW_W:0]     w_r0;
   logic [ROW_W:0]     w_r1;
   logic [COL_W:0]     w_c0;
   logic [COL_W:0]     w_c1;
   logic signed [23:0] w_top;
   logic signed [23:0] w_bot;
   logic signed [23:0] w_max;
   logic [24:0]        w_sh;
   logic [7:0]         w_q;

   assign w_chan_ok = ({28'd0, in_chan} < 32'(CHAN));
   assign w_accept  = in_valid && (r_state == S_IDLE) && w_chan_ok;
   assign w_last    = (r_row == ROW_LAST) && (r_col == COL_LAST);

   //---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   //---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_POOL;
         S_POOL:  if (w_last)   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------- outputs
   always_comb begin
      w_wr_en = (r_state == S_POOL);
      w_done  = (r_state == S_DONE);
      w_all   = (r_state == S_DONE) && (r_chan == CHAN_LAST);
      w_err   = in_valid && ((r_state != S_IDLE) || !w_chan_ok);
   end

   //---------------------------------------------------------------- pooling
   // Window (r,c) covers input rows 2r..2r+1 and cols 2c..2c+1; an odd
   // trailing row/column is therefore never addressed.
   assign w_r0 = {r_row, 1'b0};
   assign w_r1 = {r_row, 1'b1};
   assign w_c0 = {r_col, 1'b0};
   assign w_c1 = {r_col, 1'b1};

   always_comb begin
      w_top = (r_snap[w_r0][w_c0] > r_snap[w_r0][w_c1]) ? r_snap[w_r0][w_c0] : r_snap[w_r0][w_c1];
      w_bot = (r_snap[w_r1][w_c0] > r_snap[w_r1][w_c1]) ? r_snap[w_r1][w_c0] : r_snap[w_r1][w_c1];
      w_max = (w_top > w_bot) ? w_top : w_bot;
   end

   // The shifted value only matters for non-negative maxima; the 25th bit
   // keeps the rounding increment from wrapping near 0x7FFFFF.
   always_comb begin
`ifdef RELU_POOL1_ROUND_EN
      w_sh = ({1'b0, w_max} + (25'd1 << (SHIFT - 1))) >> SHIFT;
`else
      w_sh = 25'(w_max >>> SHIFT);
`endif
      if (w_max[23])             w_q = 8'd0;
      else if (w_sh > 25'd255)   w_q = 8'hFF;
      else                       w_q = w_sh[7:0];
   end

   //---------------------------------------------------------------- snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < IN_H; i++)
            for (int unsigned j = 0; j < IN_W; j++)
               r_snap[i][j] <= '0;
      end else if (w_accept) begin
         r_snap <= in_buff;
      end
   end

   //---------------------------------------------------------------- control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chan     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_ch_valid <= 1'b0;
         r_ch_idx   <= '0;
         r_all_done <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_chan <= in_chan;
            r_row  <= '0;
            r_col  <= '0;
         end else if (w_wr_en) begin
            if (r_col == COL_LAST) begin
               r_col <= '0;
               r_row <= w_last ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         r_ch_valid <= w_done;
         r_all_done <= w_all;
         if (w_done) r_ch_idx <= r_chan;
         r_busy <= (w_state_nxt != S_IDLE);
         if (w_err) r_overrun <= 1'b1;
      end
   end

   //---------------------------------------------------------------- fmap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < CHAN; k++)
            for (int unsigned i = 0; i < OUT_H; i++)
               for (int unsigned j = 0; j < OUT_W; j++)
                  r_fmap[k][i][j] <= '0;
      end else if (w_wr_en) begin
         r_fmap[r_chan][r_row][r_col] <= w_q;
      end
   end

   assign out_fmap = r_fmap;
   assign ch_valid = r_ch_valid;
   assign ch_idx   = r_ch_idx;
   assign all_done = r_all_done;
   assign busy     = r_busy;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_relu_pool1.sv
//------------------------------------------------------------------------------
// tb_relu_pool1
//
// Directed bench for relu_pool1: reset values, window ordering and latency,
// ReLU/saturation corners, snapshot isolation, back-to-back channels,
// minimum-gap acceptance, error requests and mid-operation reset.
//------------------------------------------------------------------------------
module tb_relu_pool1;

   localparam int IN_H  = 14;
   localparam int IN_W  = 13;
   localparam int OUT_H = 7;
   localparam int OUT_W = 6;
   localparam int CHAN  = 10;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [23:0] in_buff  [0:IN_H-1][0:IN_W-1];
   logic               in_valid;
   logic [3:0]         in_chan;
   logic [7:0]         out_fmap [0:CHAN-1][0:OUT_H-1][0:OUT_W-1];
   logic               ch_valid;
   logic [3:0]         ch_idx;
   logic               all_done;
   logic               busy;
   logic               overrun;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   relu_pool1 #(
      .IN_H (IN_H),
      .IN_W (IN_W),
      .OUT_H(OUT_H),
      .OUT_W(OUT_W),
      .CHAN (CHAN),
      .SHIFT(8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_buff (in_buff),
      .in_valid(in_valid),
      .in_chan (in_chan),
      .out_fmap(out_fmap),
      .ch_valid(ch_valid),
      .ch_idx  (ch_idx),
      .all_done(all_done),
      .busy    (busy),
      .overrun (overrun)
   );

   //------------------------------------------------------------ stimulus helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_const(input logic signed [23:0] v);
      for (int r = 0; r < IN_H; r++)
         for (int c = 0; c < IN_W; c++)
            in_buff[r][c] = v;
   endtask

   // Returns with the accepting edge (E0) just behind us.
   task automatic send(input logic [3:0] ch);
      in_valid = 1'b1;
      in_chan  = ch;
      tick();
      in_valid = 1'b0;
   endtask

   // Edges counted until ch_valid is seen; returns limit if it never comes.
   task automatic wait_chv(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!ch_valid && n < limit);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   //------------------------------------------------------------ tests
   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      vectors++; if (ch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ch_valid: got %b want 0", ch_valid); end
      vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL reset_ch_idx: got %0d want 0", ch_idx); end
      vectors++; if (all_done !== 1'b0) begin miscompares++; $display("FAIL reset_all_done: got %b want 0", all_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      for (int k = 0; k < CHAN; k++)
         for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++) begin
               vectors++;
               if (out_fmap[k][r][c] !== 8'd0) begin
                  miscompares++;
                  $display("FAIL reset_fmap[%0d][%0d][%0d]: got %0d want 0", k, r, c, out_fmap[k][r][c]);
               end
            end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_window();
      int n;
      for (int r = 0; r < IN_H; r++)
         for (int c = 0; c < IN_W; c++)
            in_buff[r][c] = 24'((r * IN_W + c) << 8);
      send(4'd3);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL window_busy_e0: got %b want 1", busy); end
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL window_latency: got %0d want 43", n); end
      vectors++; if (ch_idx !== 4'd3) begin miscompares++; $display("FAIL window_ch_idx: got %0d want 3", ch_idx); end
      vectors++; if (all_done !== 1'b0) begin miscompares++; $display("FAIL window_all_done: got %b want 0", all_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL window_busy_done: got %b want 0", busy); end
      tick();
      vectors++; if (ch_valid !== 1'b0) begin miscompares++; $display("FAIL window_ch_valid_pulse: got %b want 0", ch_valid); end
      for (int k = 0; k < CHAN; k++)
         for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++) begin
               logic [7:0] e;
               e = (k == 3) ? 8'((2*r + 1) * 13 + 2*c + 1) : 8'd0;
               vectors++;
               if (out_fmap[k][r][c] !== e) begin
                  miscompares++;
                  $display("FAIL window_fmap[%0d][%0d][%0d]: got %0d want %0d", k, r, c, out_fmap[k][r][c], e);
               end
            end
   endtask

   task automatic test_relu_sat();
      int n;
      logic [7:0] e [0:OUT_H-1][0:OUT_W-1];
      fill_const(-24'sd5);
      for (int r = 0; r < IN_H; r++) in_buff[r][12] = 24'sh7FFFFF;
      in_buff[0][2] = 24'sh7FFFFF;
      in_buff[1][5] = 24'sh0001FF;
      in_buff[2][0] = 24'sh010000;
      in_buff[3][3] = 24'sh00FF80;
      in_buff[2][4] = 24'sh800000;
      in_buff[4][0] = 24'sh000000;
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++)
            e[r][c] = 8'd0;
      e[0][1] = 8'd255;
`ifdef RELU_POOL1_ROUND_EN
      e[0][2] = 8'd2;
`else
      e[0][2] = 8'd1;
`endif
      e[1][0] = 8'd255;
      e[1][1] = 8'd255;
      send(4'd0);
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL relu_latency: got %0d want 43", n); end
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            vectors++;
            if (out_fmap[0][r][c] !== e[r][c]) begin
               miscompares++;
               $display("FAIL relu_fmap[0][%0d][%0d]: got %0d want %0d", r, c, out_fmap[0][r][c], e[r][c]);
            end
         end
      tick();
   endtask

   task automatic test_snapshot();
      int n;
      fill_const(24'sh004200);
      send(4'd5);
      fill_const(24'sh7FFFFF);
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL snap_latency: got %0d want 43", n); end
      vectors++; if (ch_idx !== 4'd5) begin miscompares++; $display("FAIL snap_ch_idx: got %0d want 5", ch_idx); end
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            vectors++;
            if (out_fmap[5][r][c] !== 8'h42) begin
               miscompares++;
               $display("FAIL snap_fmap[5][%0d][%0d]: got %0d want 66", r, c, out_fmap[5][r][c]);
            end
         end
      tick();
   endtask

   task automatic test_back_to_back();
      int pulses = 0, done_ok = 0, done_bad = 0, idx_bad = 0;
      for (int k = 0; k < CHAN; k++) begin
         fill_const(24'((k + 1) << 8));
         send(4'(k));
         for (int t = 0; t < 183; t++) begin
            tick();
            if (ch_valid) begin
               pulses++;
               if (ch_idx !== 4'(k)) idx_bad++;
            end
            if (all_done) begin
               if (ch_valid && ch_idx == 4'd9) done_ok++;
               else                            done_bad++;
            end
         end
      end
      vectors++; if (pulses != 10) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 10", pulses); end
      vectors++; if (idx_bad != 0) begin miscompares++; $display("FAIL b2b_ch_idx: got %0d wrong want 0", idx_bad); end
      vectors++; if (done_ok != 1) begin miscompares++; $display("FAIL b2b_all_done: got %0d want 1", done_ok); end
      vectors++; if (done_bad != 0) begin miscompares++; $display("FAIL b2b_all_done_stray: got %0d want 0", done_bad); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
      for (int k = 0; k < CHAN; k++)
         for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++) begin
               vectors++;
               if (out_fmap[k][r][c] !== 8'(k + 1)) begin
                  miscompares++;
                  $display("FAIL b2b_fmap[%0d][%0d][%0d]: got %0d want %0d", k, r, c, out_fmap[k][r][c], k + 1);
               end
            end
   endtask

   task automatic test_min_gap();
      int n;
      fill_const(24'sh000B00);
      send(4'd1);
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL gap_latency1: got %0d want 43", n); end
      fill_const(24'sh000C00);
      send(4'd2);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy: got %b want 1", busy); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL gap_overrun: got %b want 0", overrun); end
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL gap_latency2: got %0d want 43", n); end
      vectors++; if (ch_idx !== 4'd2) begin miscompares++; $display("FAIL gap_ch_idx: got %0d want 2", ch_idx); end
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            vectors++;
            if (out_fmap[1][r][c] !== 8'd11 || out_fmap[2][r][c] !== 8'd12) begin
               miscompares++;
               $display("FAIL gap_fmap[%0d][%0d]: got %0d/%0d want 11/12", r, c, out_fmap[1][r][c], out_fmap[2][r][c]);
            end
         end
      tick();
   endtask

   task automatic test_bad_chan();
      int n;
      logic [3:0] bad [0:1];
      bad[0] = 4'd10;
      bad[1] = 4'd12;
      for (int i = 0; i < 2; i++) begin
         do_reset();
         vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL badch_pre_overrun: got %b want 0", overrun); end
         fill_const(24'sh000500);
         send(bad[i]);
         vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL badch_overrun ch=%0d: got %b want 1", bad[i], overrun); end
         vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL badch_busy ch=%0d: got %b want 0", bad[i], busy); end
         wait_chv(60, n);
         vectors++; if (n != 60 || ch_valid !== 1'b0) begin miscompares++; $display("FAIL badch_no_ch_valid ch=%0d: got pulse after %0d want none", bad[i], n); end
      end
   endtask

   task automatic test_overrun_busy();
      int n;
      do_reset();
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_pre: got %b want 0", overrun); end
      fill_const(24'sh000700);
      send(4'd7);
      repeat (10) tick();
      fill_const(24'sh006300);
      in_valid = 1'b1;
      in_chan  = 4'd2;
      tick();
      in_valid = 1'b0;
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %b want 1", overrun); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovr_busy: got %b want 1", busy); end
      wait_chv(100, n);
      vectors++; if (n != 32) begin miscompares++; $display("FAIL ovr_latency: got %0d want 32", n); end
      vectors++; if (ch_idx !== 4'd7) begin miscompares++; $display("FAIL ovr_ch_idx: got %0d want 7", ch_idx); end
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            vectors++;
            if (out_fmap[7][r][c] !== 8'd7 || out_fmap[2][r][c] !== 8'd0) begin
               miscompares++;
               $display("FAIL ovr_fmap[%0d][%0d]: got %0d/%0d want 7/0", r, c, out_fmap[7][r][c], out_fmap[2][r][c]);
            end
         end
      tick();
      vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovr_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int n;
      fill_const(24'sh000900);
      send(4'd4);
      repeat (21) tick();
      vectors++; if (out_fmap[4][3][2] !== 8'd9) begin miscompares++; $display("FAIL mid_win20: got %0d want 9", out_fmap[4][3][2]); end
      vectors++; if (out_fmap[4][3][3] !== 8'd0) begin miscompares++; $display("FAIL mid_win21: got %0d want 0", out_fmap[4][3][3]); end
      #3;
      rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL mid_overrun: got %b want 0", overrun); end
      vectors++; if (ch_valid !== 1'b0 || all_done !== 1'b0) begin miscompares++; $display("FAIL mid_pulses: got %b/%b want 0/0", ch_valid, all_done); end
      vectors++; if (ch_idx !== 4'd0) begin miscompares++; $display("FAIL mid_ch_idx: got %0d want 0", ch_idx); end
      for (int k = 0; k < CHAN; k++)
         for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++) begin
               vectors++;
               if (out_fmap[k][r][c] !== 8'd0) begin
                  miscompares++;
                  $display("FAIL mid_fmap[%0d][%0d][%0d]: got %0d want 0", k, r, c, out_fmap[k][r][c]);
               end
            end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send(4'd4);
      wait_chv(100, n);
      vectors++; if (n != 43) begin miscompares++; $display("FAIL mid_latency: got %0d want 43", n); end
      vectors++; if (ch_idx !== 4'd4) begin miscompares++; $display("FAIL mid_ch_idx2: got %0d want 4", ch_idx); end
      for (int r = 0; r < OUT_H; r++)
         for (int c = 0; c < OUT_W; c++) begin
            vectors++;
            if (out_fmap[4][r][c] !== 8'd9) begin
               miscompares++;
               $display("FAIL mid_fmap2[4][%0d][%0d]: got %0d want 9", r, c, out_fmap[4][r][c]);
            end
         end
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_chan  = 4'd0;
      fill_const(24'sd0);
      test_reset();
      test_window();
      test_relu_sat();
      test_snapshot();
      test_back_to_back();
      test_min_gap();
      test_bad_chan();
      test_overrun_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
